// File: rtl/fx3_iq_unpacker_pkg.sv
// Shared I/Q beat definitions for the FX3 sample unpacker and its transmit-side packer.
// Holds the default beat width, the iqsel tag encoding and the pairing-state type.
package fx3_iq_unpacker_pkg;

  localparam int   IQ_W_DEF = 12;
  localparam int   WORD_W_DEF = 2 * IQ_W_DEF;
  localparam logic SEL_I = 1'b0;
  localparam logic SEL_Q = 1'b1;

  typedef enum logic {
    WAIT_I = 1'b0,
    HAVE_I = 1'b1
  } pair_state_e;

endpackage

// File: rtl/fx3_iq_skid_fifo.sv
// Two-entry output buffer. The head entry is a register that drives the master data
// port directly, so m_data stays stable while a word is waiting for ready.
module fx3_iq_skid_fifo #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_full
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [1:0]   r_count;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_data    = r_head;
  assign o_valid   = (r_count != 2'd0);
  assign o_full    = (r_count == 2'd2);
  assign w_do_pop  = i_pop & o_valid;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_do_push, w_do_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_data;
          else                 r_tail <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps the count; the new word lands behind any survivor.
          if (r_count == 2'd1) begin
            r_head <= i_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fx3_iq_unpacker.sv
// Pairs tagged I/Q sample beats into {Q, I} words, flags out-of-order beats and counts
// them in a saturating, clearable error counter.
module fx3_iq_unpacker
  import fx3_iq_unpacker_pkg::*;
#(
  parameter int IQ_W      = IQ_W_DEF,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IQ_W-1:0]      s_data_i,
  input  logic                 s_iqsel_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  output logic [2*IQ_W-1:0]    m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  input  logic                 err_clr_i
);

  localparam logic [ERR_CNT_W-1:0] CNT_ONE = 1;

  pair_state_e          r_state;
  logic [IQ_W-1:0]      r_held_i;
  logic                 r_rdy_en;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic                 w_s_fire;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_seq_err;
  logic [2*IQ_W-1:0]    w_word;

  // Ready comes only from registers; r_rdy_en holds it low for the first edge after reset.
  assign s_ready_o = r_rdy_en & ((r_state == WAIT_I) | ~w_full);
  assign w_s_fire  = s_valid_i & s_ready_o;
  assign w_push    = w_s_fire & (r_state == HAVE_I) & (s_iqsel_i == SEL_Q);
  assign w_pop     = m_valid_o & m_ready_i;
  assign w_seq_err = w_s_fire &
                     (((r_state == WAIT_I) & (s_iqsel_i == SEL_Q)) |
                      ((r_state == HAVE_I) & (s_iqsel_i == SEL_I)));
  assign w_word    = {s_data_i, r_held_i};

  assign err_o     = r_err;
  assign err_cnt_o = r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= WAIT_I;
      r_held_i  <= '0;
      r_rdy_en  <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      r_err    <= w_seq_err;
      if (err_clr_i)
        r_err_cnt <= '0;
      else if (w_seq_err && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + CNT_ONE;
      if (w_s_fire) begin
        case (r_state)
          WAIT_I: begin
            if (s_iqsel_i == SEL_I) begin
              r_held_i <= s_data_i;
              r_state  <= HAVE_I;
            end
          end
          HAVE_I: begin
            // A second I resyncs to the newest one; a Q completes the pair.
            if (s_iqsel_i == SEL_I) r_held_i <= s_data_i;
            else                    r_state  <= WAIT_I;
          end
          default: r_state <= WAIT_I;
        endcase
      end
    end
  end

  fx3_iq_skid_fifo #(
    .W (2 * IQ_W)
  ) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_data  (m_data_o),
    .o_valid (m_valid_o),
    .o_full  (w_full)
  );

endmodule

// File: tb/tb_fx3_iq_unpacker.sv
// Self-checking bench for fx3_iq_unpacker: directed scenarios plus random traffic,
// checked every cycle against a transaction-level pairing model with an expected queue.
module tb_fx3_iq_unpacker;

  localparam int IQ_W     = 12;
  localparam int W        = 2 * IQ_W;
  localparam int ERR_W    = 4;
  localparam int CNT_MAX  = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [IQ_W-1:0]  s_data_i;
  logic             s_iqsel_i;
  logic             s_valid_i;
  logic             s_ready_o;
  logic [W-1:0]     m_data_o;
  logic             m_valid_o;
  logic             m_ready_i;
  logic             err_o;
  logic [ERR_W-1:0] err_cnt_o;
  logic             err_clr_i;

  fx3_iq_unpacker #(
    .IQ_W      (IQ_W),
    .ERR_CNT_W (ERR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data_i),
    .s_iqsel_i (s_iqsel_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .m_data_o  (m_data_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .err_o     (err_o),
    .err_cnt_o (err_cnt_o),
    .err_clr_i (err_clr_i)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0]    exp_q[$];
  logic            m_has_i;
  logic [IQ_W-1:0] m_held;
  logic            m_err_pend;
  int unsigned     m_cnt;
  logic            m_rdy_en;

  int n_checks = 0;
  int n_fail   = 0;
  int dut_words = 0;
  int dut_not_ready = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_has_i    = 1'b0;
    m_held     = '0;
    m_err_pend = 1'b0;
    m_cnt      = 0;
    m_rdy_en   = 1'b0;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input logic v, input logic sel, input logic [IQ_W-1:0] d,
                      input logic mr, input logic clr, output logic acc);
    logic exp_rdy;
    logic err_now;
    s_valid_i = v;
    s_iqsel_i = sel;
    s_data_i  = d;
    m_ready_i = mr;
    err_clr_i = clr;
    @(negedge clk);
    exp_rdy = m_rdy_en && (!m_has_i || exp_q.size() < 2);
    chk("s_ready", 32'(s_ready_o), 32'(exp_rdy));
    chk("m_valid", 32'(m_valid_o), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("m_data", 32'(m_data_o), 32'(exp_q[0]));
    chk("err_pulse", 32'(err_o), 32'(m_err_pend));
    chk("err_cnt", 32'(err_cnt_o), 32'(m_cnt));
    if (m_valid_o && mr) dut_words++;
    if (!s_ready_o) dut_not_ready++;
    acc     = v && exp_rdy;
    err_now = 1'b0;
    if (mr && exp_q.size() != 0) void'(exp_q.pop_front());
    if (acc) begin
      if (sel) begin
        if (m_has_i) begin
          exp_q.push_back({d, m_held});
          m_has_i = 1'b0;
        end else begin
          err_now = 1'b1;
        end
      end else begin
        if (m_has_i) err_now = 1'b1;
        m_held  = d;
        m_has_i = 1'b1;
      end
    end
    m_err_pend = err_now;
    if (clr) m_cnt = 0;
    else if (err_now && m_cnt < CNT_MAX) m_cnt++;
    m_rdy_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic mr, input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, mr, 1'b0, acc);
  endtask

  task automatic send(input logic sel, input logic [IQ_W-1:0] d, input logic mr);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      step(1'b1, sel, d, mr, 1'b0, acc);
      n++;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout observed=not_accepted expected=accepted");
    end
  endtask

  task automatic do_reset();
    s_valid_i = 1'b0;
    m_ready_i = 1'b0;
    err_clr_i = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    #1;
    chk("rst_m_valid", 32'(m_valid_o), 32'd0);
    chk("rst_s_ready", 32'(s_ready_o), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt_o), 32'd0);
    chk("rst_m_data", 32'(m_data_o), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    int   base;
    s_data_i  = '0;
    s_iqsel_i = 1'b0;

    // Reset and single pair with one-cycle latency
    do_reset();
    send(1'b0, 12'h123, 1'b1);
    send(1'b1, 12'hABC, 1'b1);
    chk("lat_valid", 32'(m_valid_o), 32'd1);
    chk("lat_data", 32'(m_data_o), 32'h00ABC123);
    idle(1'b1, 2);
    chk("pair_err_cnt", 32'(err_cnt_o), 32'd0);

    // Sequence errors: stray Q, double I
    do_reset();
    idle(1'b1, 1);
    send(1'b1, 12'h001, 1'b1);
    send(1'b0, 12'h010, 1'b1);
    send(1'b0, 12'h020, 1'b1);
    send(1'b1, 12'h030, 1'b1);
    chk("seq_word", 32'(m_data_o), 32'h00030020);
    idle(1'b1, 2);
    chk("seq_err_cnt", 32'(err_cnt_o), 32'd2);

    // 100 back-to-back words at full rate
    do_reset();
    idle(1'b1, 1);
    base = dut_not_ready;
    dut_words = 0;
    for (int i = 0; i < 100; i++) begin
      send(1'b0, 12'($urandom_range(0, 4095)), 1'b1);
      send(1'b1, 12'($urandom_range(0, 4095)), 1'b1);
    end
    idle(1'b1, 2);
    chk("full_rate_words", 32'(dut_words), 32'd100);
    chk("full_rate_no_drop", 32'(dut_not_ready - base), 32'd0);

    // Backpressure: two words buffered, third pair stalls in HAVE_I
    do_reset();
    idle(1'b0, 1);
    dut_words = 0;
    send(1'b0, 12'h111, 1'b0);
    send(1'b1, 12'h222, 1'b0);
    send(1'b0, 12'h333, 1'b0);
    send(1'b1, 12'h444, 1'b0);
    send(1'b0, 12'h555, 1'b0);
    chk("stall_s_ready", 32'(s_ready_o), 32'd0);
    chk("stall_hold_data", 32'(m_data_o), 32'h00222111);
    step(1'b1, 1'b1, 12'h666, 1'b0, 1'b0, acc);
    step(1'b1, 1'b1, 12'h666, 1'b0, 1'b0, acc);
    chk("stall_hold_data2", 32'(m_data_o), 32'h00222111);
    send(1'b1, 12'h666, 1'b1);
    idle(1'b1, 4);
    chk("stall_words", 32'(dut_words), 32'd3);

    // Counter saturation, then clear colliding with an error
    do_reset();
    idle(1'b1, 1);
    for (int i = 0; i < CNT_MAX + 5; i++) send(1'b1, 12'($urandom_range(0, 4095)), 1'b1);
    idle(1'b1, 1);
    chk("sat_cnt", 32'(err_cnt_o), 32'(CNT_MAX));
    step(1'b1, 1'b1, 12'h0, 1'b1, 1'b1, acc);
    chk("clr_wins", 32'(err_cnt_o), 32'd0);
    idle(1'b1, 1);

    // Reset mid-word with a buffered word and a held I
    do_reset();
    idle(1'b0, 1);
    send(1'b0, 12'h0AA, 1'b0);
    send(1'b1, 12'h0BB, 1'b0);
    send(1'b0, 12'h0CC, 1'b0);
    chk("pre_rst_valid", 32'(m_valid_o), 32'd1);
    do_reset();
    send(1'b0, 12'h5A5, 1'b1);
    send(1'b1, 12'hA5A, 1'b1);
    chk("post_rst_data", 32'(m_data_o), 32'h00A5A5A5);
    idle(1'b1, 2);

    // Random traffic
    do_reset();
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           12'($urandom_range(0, 4095)), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 31) == 0), acc);
    end
    idle(1'b1, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
